// File: rtl/gpi_debounce_pkg.sv
// gpi_debounce_pkg: shared defaults and types for the general-purpose input conditioner.
package gpi_debounce_pkg;
    localparam int GpiWidthDefault    = 20;
    localparam int GpiDebounceDefault = 500000;  // 10 ms at 50 MHz
    localparam int GpiCntWidthDefault = 20;
    typedef logic [GpiWidthDefault-1:0] gpi_vec_t;
endpackage

// File: rtl/gpi_debounce_chan.sv
// gpi_debounce_chan: one input channel - synchroniser, bounce filter and edge pulses.
module gpi_debounce_chan
    import gpi_debounce_pkg::*;
#(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = GpiDebounceDefault,
    parameter int CntWidth       = GpiCntWidthDefault
) (
    input  logic clk_sys_i,
    input  logic rst_sys_ni,
    input  logic raw_i,
    output logic gp_o,
    output logic rise_o,
    output logic fall_o
);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);
    logic [SyncStages-1:0] sync_q, sync_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic stable_q, stable_d, rise_q, rise_d, fall_q, fall_d;
    logic sync, accept;
    assign sync   = sync_q[SyncStages-1];
    assign accept = (sync != stable_q) && (cnt_q == CntMax);
    // Any return to the stable level restarts the count, so bounce never accumulates.
    always_comb begin
        sync_d   = {sync_q[SyncStages-2:0], raw_i};
        cnt_d    = (sync == stable_q || accept) ? '0 : cnt_q + 1'b1;
        stable_d = accept ? sync : stable_q;
        rise_d   = accept & sync;
        fall_d   = accept & ~sync;
    end
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end
    assign gp_o   = stable_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/gpi_debounce.sv
// gpi_debounce: Width-channel pad conditioner for gp_i; define GPI_DEBOUNCE_EVT_EN for
// sticky edge-event bits with a combined interrupt.
module gpi_debounce
    import gpi_debounce_pkg::*;
#(
    parameter int Width          = GpiWidthDefault,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = GpiDebounceDefault,
    parameter int CntWidth       = GpiCntWidthDefault
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
`ifdef GPI_DEBOUNCE_EVT_EN
    ,
    input  logic [Width-1:0] evt_clr_i,
    output logic [Width-1:0] evt_o,
    output logic             irq_o
`endif
);
    for (genvar i = 0; i < Width; i++) begin : g_chan
        gpi_debounce_chan #(
            .SyncStages    (SyncStages),
            .DebounceCycles(DebounceCycles),
            .CntWidth      (CntWidth)
        ) u_chan (
            .clk_sys_i (clk_sys_i),
            .rst_sys_ni(rst_sys_ni),
            .raw_i     (raw_i[i]),
            .gp_o      (gp_o[i]),
            .rise_o    (rise_o[i]),
            .fall_o    (fall_o[i])
        );
    end
`ifdef GPI_DEBOUNCE_EVT_EN
    logic [Width-1:0] evt_q, evt_d;
    // A new edge outranks a clear arriving in the same cycle.
    always_comb begin
        evt_d = rise_o | fall_o | (evt_q & ~evt_clr_i);
    end
    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end
    assign evt_o = evt_q;
    assign irq_o = |evt_q;
`endif
endmodule

// File: tb/tb_gpi_debounce.sv
// tb_gpi_debounce: scoreboard bench for gpi_debounce (SyncStages=2, DebounceCycles=4, Width=20).
module tb_gpi_debounce;
    import gpi_debounce_pkg::*;
    localparam int Lat = 6;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    gpi_vec_t raw = '0;
    gpi_vec_t gp, rise, fall;
`ifdef GPI_DEBOUNCE_EVT_EN
    gpi_vec_t clr = '0;
    gpi_vec_t evt;
    logic irq;
`endif
    typedef struct packed {
        gpi_vec_t gp;
        gpi_vec_t rise;
        gpi_vec_t fall;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpi_debounce #(
        .Width(20),
        .SyncStages(2),
        .DebounceCycles(4),
        .CntWidth(20)
    ) dut (
        .clk_sys_i (clk),
        .rst_sys_ni(rst_n),
        .raw_i     (raw),
        .gp_o      (gp),
        .rise_o    (rise),
        .fall_o    (fall)
`ifdef GPI_DEBOUNCE_EVT_EN
        ,
        .evt_clr_i (clr),
        .evt_o     (evt),
        .irq_o     (irq)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        raw   = '1;
        for (int k = 1; k <= 5; k++) q.push_back('{gp: '0, rise: '0, fall: '0});
        for (int k = 1; k <= 5; k++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({gp, rise, fall} !== e) begin
                errors++;
                $display("FAIL reset cyc %0d got gp=%h rise=%h fall=%h want gp=%h rise=%h fall=%h",
                         k, gp, rise, fall, e.gp, e.rise, e.fall);
            end
`ifdef GPI_DEBOUNCE_EVT_EN
            checks++;
            if ({evt, irq} !== 21'h0) begin
                errors++;
                $display("FAIL reset_evt cyc %0d got evt=%h irq=%b want 0", k, evt, irq);
            end
`endif
        end
        raw = '0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_edges(input string name, input gpi_vec_t m);
        for (int d = 0; d < 2; d++) begin
            raw = (d == 0) ? (raw | m) : (raw & ~m);
            for (int k = 1; k <= Lat + 2; k++) begin
                if (d == 0) q.push_back('{gp: (k >= Lat) ? m : '0, rise: (k == Lat) ? m : '0, fall: '0});
                else q.push_back('{gp: (k < Lat) ? m : '0, rise: '0, fall: (k == Lat) ? m : '0});
            end
            for (int k = 1; k <= Lat + 2; k++) begin
                step();
                e = q.pop_front();
                checks++;
                if ({gp, rise, fall} !== e) begin
                    errors++;
                    $display("FAIL %s dir %0d cyc %0d got gp=%h rise=%h fall=%h want gp=%h rise=%h fall=%h",
                             name, d, k, gp, rise, fall, e.gp, e.rise, e.fall);
                end
            end
        end
    endtask

    task automatic test_bounce;
        for (int k = 0; k < 28; k++) begin
            raw[3] = (k < 20) ? (((k / 2) % 2) == 0) : 1'b0;
            q.push_back('{gp: '0, rise: '0, fall: '0});
            step();
            e = q.pop_front();
            checks++;
            if ({gp, rise, fall} !== e) begin
                errors++;
                $display("FAIL bounce cyc %0d got gp=%h rise=%h fall=%h want all 0", k, gp, rise, fall);
            end
        end
    endtask

    task automatic test_reset_mid;
        raw[1] = 1'b1;
        for (int k = 1; k <= 3; k++) q.push_back('{gp: '0, rise: '0, fall: '0});
        for (int k = 1; k <= 3; k++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({gp, rise, fall} !== e) begin
                errors++;
                $display("FAIL pre_reset cyc %0d got gp=%h rise=%h want 0", k, gp, rise);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gp, rise, fall} !== 60'h0) begin
            errors++;
            $display("FAIL mid_reset got gp=%h rise=%h fall=%h want 0", gp, rise, fall);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 1; k <= Lat + 2; k++)
            q.push_back('{gp: (k >= Lat) ? 20'h2 : '0, rise: (k == Lat) ? 20'h2 : '0, fall: '0});
        for (int k = 1; k <= Lat + 2; k++) begin
            step();
            e = q.pop_front();
            checks++;
            if ({gp, rise, fall} !== e) begin
                errors++;
                $display("FAIL post_reset cyc %0d got gp=%h rise=%h fall=%h want gp=%h rise=%h fall=%h",
                         k, gp, rise, fall, e.gp, e.rise, e.fall);
            end
        end
    endtask

`ifdef GPI_DEBOUNCE_EVT_EN
    task automatic test_events;
        raw = '0;
        repeat (Lat + 2) step();
        clr = '1;
        step();
        clr = '0;
        checks++;
        if ({evt, irq} !== 21'h0) begin
            errors++;
            $display("FAIL evt_clear_all got evt=%h irq=%b want 0", evt, irq);
        end
        raw[2] = 1'b1;
        for (int k = 1; k <= Lat + 1; k++) begin
            step();
            if (k == Lat) begin
                checks++;
                if ({rise, evt, irq} !== {20'h4, 20'h0, 1'b0}) begin
                    errors++;
                    $display("FAIL evt_pulse got rise=%h evt=%h irq=%b want rise=4 evt=0 irq=0", rise, evt, irq);
                end
            end
        end
        checks++;
        if ({evt, irq} !== {20'h4, 1'b1}) begin
            errors++;
            $display("FAIL evt_set got evt=%h irq=%b want evt=4 irq=1", evt, irq);
        end
        raw[2] = 1'b0;
        for (int k = 1; k <= Lat; k++) step();
        checks++;
        if (fall !== 20'h4) begin
            errors++;
            $display("FAIL evt_fall got fall=%h want 4", fall);
        end
        clr[2] = 1'b1;
        step();
        clr = '0;
        checks++;
        if ({evt, irq} !== {20'h4, 1'b1}) begin
            errors++;
            $display("FAIL evt_set_wins got evt=%h irq=%b want evt=4 irq=1", evt, irq);
        end
        clr[2] = 1'b1;
        step();
        clr = '0;
        checks++;
        if ({evt, irq} !== 21'h0) begin
            errors++;
            $display("FAIL evt_clr got evt=%h irq=%b want 0", evt, irq);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_edges("single_ch0", 20'h1);
        test_bounce();
        test_edges("all_ch", 20'hFFFFF);
        test_reset_mid();
`ifdef GPI_DEBOUNCE_EVT_EN
        test_events();
`endif
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d entries want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
